// File: rtl/adder_arb_pkg.sv
// Shared types and configuration for the adder-sharing arbiter.
// ID_W tracks ARB_NUM_REQ; a top-level NUM_REQ override must keep ARB_NUM_REQ in step.
package adder_arb_pkg;

  localparam int unsigned ARB_NUM_REQ   = 4;
  localparam int unsigned ARB_DATA_W    = 8;
  localparam int unsigned ARB_ADD_LAT   = 1;
  localparam int unsigned ARB_BURST_LEN = 4;

  localparam int unsigned ID_W = $clog2(ARB_NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // Next requester index with wrap at n-1 -> 0 (n need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx,
                                                input int unsigned     n);
    if (32'(idx) + 32'd1 >= n) begin
      return '0;
    end
    return ID_W'(32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_picker.sv
// Round-robin picker: first asserted request at or above the pointer, with wrap.
// Purely combinational; grant is one-hot or zero.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[IDX_W'(j)]) begin
        any_o               = 1'b1;
        gnt_o[IDX_W'(j)]    = 1'b1;
        idx_o               = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one adder between NUM_REQ requesters with round-robin burst arbitration,
// and returns each sum tagged with the requester that issued it.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = ARB_NUM_REQ,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned ADD_LAT   = ARB_ADD_LAT,
  parameter int unsigned BURST_LEN = ARB_BURST_LEN
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
  output logic [DATA_W-1:0]           add_a_o,
  output logic [DATA_W-1:0]           add_b_o,
  input  logic [DATA_W-1:0]           add_x_i,
  output logic                        rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        busy_o
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned DEPTH = ADD_LAT + 1;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] add_a_q, add_a_d;
  logic [DATA_W-1:0] add_b_q, add_b_d;
  tag_t [DEPTH-1:0] pipe_q;
  tag_t             tag_in;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] ready;
  logic [ID_W-1:0]    lane;
  logic               beat;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Grant: free pick in IDLE, owner-only in BURST, nothing while in reset.
  always_comb begin
    ready = '0;
    lane  = owner_q;
    if (!reset_i) begin
      if (state_q == IDLE) begin
        ready = pick_gnt;
        lane  = pick_idx;
      end else begin
        ready[owner_q] = 1'b1;
      end
    end
  end

  assign beat = (state_q == IDLE) ? (pick_any && !reset_i)
                                  : |(req_valid_i & ready);

  // Operand capture; hold last operands when no beat is accepted.
  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (beat) begin
      add_a_d = req_a_i[32'(lane)*DATA_W +: DATA_W];
      add_b_d = req_b_i[32'(lane)*DATA_W +: DATA_W];
    end
  end

  // Arbitration FSM: burst ends on the BURST_LEN-th beat or when the owner drops valid.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
          if (BURST_LEN > 32'd1) begin
            state_d = BURST;
          end else begin
            ptr_d = wrap_inc(pick_idx, NUM_REQ);
          end
        end
      end
      BURST: begin
        if (!req_valid_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q, NUM_REQ);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q, NUM_REQ);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = beat;
    tag_in.id  = lane;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      pipe_q  <= {pipe_q[DEPTH-2:0], tag_in};
    end
  end

  // Responses still in the pipe when reset is raised are never presented.
  always_comb begin
    busy_o = (state_q == BURST);
    for (int unsigned s = 0; s < DEPTH; s++) begin
      busy_o = busy_o | pipe_q[s].vld;
    end
  end

  assign req_ready_o = ready;
  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign rsp_valid_o = pipe_q[DEPTH-1].vld & ~reset_i;
  assign rsp_id_o    = pipe_q[DEPTH-1].id;
  assign rsp_data_o  = rsp_valid_o ? add_x_i : '0;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with a one-cycle registered adder model.
module tb_adder_share_arb;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [7:0]  add_x = 8'h00;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Adder: io_X follows the operands one cycle later, 8-bit wrap.
  always @(posedge clk) add_x <= 8'(add_a + add_b);

  adder_share_arb #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .ADD_LAT   (1),
    .BURST_LEN (4)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_x_i     (add_x),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] er, input logic erv,
                     input logic [1:0] eid, input logic [7:0] edata);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'(er));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(erv));
    if (erv) begin
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(eid));
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(edata));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i   = 1'b1;
    req_valid = 4'h0;
    req_a     = '0;
    req_b     = '0;
    @(posedge clk);
    #1;

    // 1: reset held, no traffic
    for (int i = 0; i < 10; i++) cyc("t1_rst", 4'h0, 1'b0, 2'd0, 8'h00);
    chk("t1_add_a", 32'(add_a), 32'h0);
    chk("t1_add_b", 32'(add_b), 32'h0);
    reset_i = 1'b0;
    cyc("t1_idle", 4'h0, 1'b0, 2'd0, 8'h00);
    chk("t1_rsp_id", 32'(rsp_id), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);

    // 2: lane 0 alone, one full burst of 0x12+0x34
    set_lane(0, 8'h12, 8'h34);
    req_valid = 4'b0001;
    cyc("t2_b0", 4'b0001, 1'b0, 2'd0, 8'h00);
    chk("t2_busy_burst", 32'(busy), 32'h1);
    cyc("t2_b1", 4'b0001, 1'b0, 2'd0, 8'h00);
    cyc("t2_b2", 4'b0001, 1'b1, 2'd0, 8'h46);
    cyc("t2_b3", 4'b0001, 1'b1, 2'd0, 8'h46);
    req_valid = 4'b0000;
    cyc("t2_r2", 4'b0000, 1'b1, 2'd0, 8'h46);
    cyc("t2_r3", 4'b0000, 1'b1, 2'd0, 8'h46);
    cyc("t2_done", 4'b0000, 1'b0, 2'd0, 8'h00);
    chk("t2_busy_idle", 32'(busy), 32'h0);
    req_valid = 4'b0011;
    #2;
    chk("t2_ptr1", 32'(req_ready), 32'b0010);
    req_valid = 4'b0000;

    // 3: all lanes valid, pointer back to 0 via reset
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    set_lane(0, 8'h10, 8'h01);
    set_lane(1, 8'h20, 8'h02);
    set_lane(2, 8'h30, 8'h03);
    set_lane(3, 8'h40, 8'h04);
    req_valid = 4'hF;
    for (int j = 0; j < 22; j++) begin
      logic [3:0] er;
      logic [1:0] eid;
      if (j == 20) req_valid = 4'h0;
      er  = (j < 20) ? 4'(1 << ((j / 4) % 4)) : 4'h0;
      eid = (j >= 2) ? 2'(((j - 2) / 4) % 4) : 2'd0;
      cyc("t3_rr", er, (j >= 2), eid, 8'(8'h11 * (32'(eid) + 1)));
    end

    // 4: lane 2 drops valid mid-burst
    req_valid = 4'b1100;
    cyc("t4_m0", 4'b0100, 1'b0, 2'd0, 8'h00);
    cyc("t4_m1", 4'b0100, 1'b0, 2'd0, 8'h00);
    req_valid = 4'b1000;
    cyc("t4_bubble", 4'b0100, 1'b1, 2'd2, 8'h33);
    cyc("t4_l3", 4'b1000, 1'b1, 2'd2, 8'h33);
    req_valid = 4'b0000;
    cyc("t4_m4", 4'b1000, 1'b0, 2'd0, 8'h00);
    cyc("t4_m5", 4'b0000, 1'b1, 2'd3, 8'h44);
    cyc("t4_m6", 4'b0000, 1'b0, 2'd0, 8'h00);

    // 5: sum wrap on lane 1
    set_lane(1, 8'hFF, 8'h02);
    req_valid = 4'b0010;
    cyc("t5_n0", 4'b0010, 1'b0, 2'd0, 8'h00);
    req_valid = 4'b0000;
    cyc("t5_n1", 4'b0010, 1'b0, 2'd0, 8'h00);
    cyc("t5_wrap", 4'b0000, 1'b1, 2'd1, 8'h01);
    cyc("t5_n3", 4'b0000, 1'b0, 2'd0, 8'h00);

    // 6: reset with two ops in flight from lane 3
    req_valid = 4'b1000;
    cyc("t6_p0", 4'b1000, 1'b0, 2'd0, 8'h00);
    cyc("t6_p1", 4'b1000, 1'b0, 2'd0, 8'h00);
    reset_i = 1'b1;
    cyc("t6_rst", 4'b0000, 1'b0, 2'd0, 8'h00);
    reset_i   = 1'b0;
    req_valid = 4'b1001;
    cyc("t6_p3", 4'b0001, 1'b0, 2'd0, 8'h00);
    req_valid = 4'b0000;
    cyc("t6_p4", 4'b0001, 1'b0, 2'd0, 8'h00);
    cyc("t6_p5", 4'b0000, 1'b1, 2'd0, 8'h11);
    cyc("t6_p6", 4'b0000, 1'b0, 2'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
